fifo_wr_arbiter: RTL

Round-robin controller that shares one FIFO write port among NUM_REQ producers. It also tracks FIFO occupancy against a consumer read strobe. Each cycle it picks at most one requester, drives the FIFO write enable, write pointer and write data, and maintains the read pointer, occupancy count, full/empty flags and overflow/underflow pulses. It sits between the producer blocks and the FIFO storage array, and replaces per-producer input control.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_rr_picker.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared constants and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int STAT_W      = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: lowest rotational distance from rr_ptr wins.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot
);

  int best_off;
  int off;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    best_off = NUM_REQ;
    off      = 0;
    winner   = '0;
    onehot   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i - int'(rr_ptr) + NUM_REQ) % NUM_REQ;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        winner   = IDX_W'(i);
      end
    end
    valid = (best_off < NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      onehot[i] = valid && (winner == IDX_W'(i));
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port plus occupancy/flag tracking.
// Optional statistics counters (drop_cnt, grant_cnt) behind macro FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int PTR_W   = clog2(DEPTH),
  parameter int CNT_W   = clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] din,
  input  logic                      rd_en,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      fifo_wr_en,
  output logic [PTR_W-1:0]          fifo_wr_ptr,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [PTR_W-1:0]          fifo_rd_ptr,
  output logic [CNT_W-1:0]          count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]         drop_cnt,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt
`endif
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [DATA_W-1:0]  wdata_sel;
  logic               wr_accept;
  logic               rd_accept;

  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               wr_en_q, wr_en_d;
  logic [PTR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner),
    .onehot (pick_onehot)
  );

  always_comb begin
    wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) wdata_sel = din[i*DATA_W +: DATA_W];
    end
  end

  // Arbitration uses the registered full flag: a full FIFO never takes a write,
  // even when a read frees a slot in the same cycle.
  always_comb begin
    wr_accept   = pick_valid && !full_q;
    rd_accept   = rd_en && !empty_q;
    grant_d     = wr_accept ? pick_onehot : '0;
    wr_en_d     = wr_accept;
    wr_addr_d   = wr_accept ? wr_ptr_q : wr_addr_q;
    wdata_d     = wr_accept ? wdata_sel : wdata_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(wr_accept);
    rd_ptr_d    = rd_ptr_q + PTR_W'(rd_accept);
    rr_ptr_d    = rr_ptr_q;
    if (wr_accept) begin
      rr_ptr_d = (pick_winner == IDX_W'(NUM_REQ - 1)) ? '0 : pick_winner + IDX_W'(1);
    end
    count_d     = count_q + CNT_W'(wr_accept) - CNT_W'(rd_accept);
    full_d      = (count_d == FULL_CNT);
    empty_d     = (count_d == '0);
    overflow_d  = pick_valid && full_q;
    underflow_d = rd_en && empty_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wdata_q     <= wdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rr_ptr_q    <= rr_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign grant       = grant_q;
  assign fifo_wr_en  = wr_en_q;
  assign fifo_wr_ptr = wr_addr_q;
  assign fifo_wdata  = wdata_q;
  assign fifo_rd_ptr = rd_ptr_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0]         drop_cnt_q;
  logic [NUM_REQ*STAT_W-1:0] grant_cnt_q;

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_q  <= '0;
      grant_cnt_q <= '0;
    end else begin
      if (overflow_d && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + STAT_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_d[i] && (grant_cnt_q[i*STAT_W +: STAT_W] != '1)) begin
          grant_cnt_q[i*STAT_W +: STAT_W] <= grant_cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
        end
      end
    end
  end

  assign drop_cnt  = drop_cnt_q;
  assign grant_cnt = grant_cnt_q;
`endif

endmodule
